utf8_stream_decoder: RTL

- Upstream neighbour of the terminal character stage.
- Accepts a raw byte stream (UART or host bridge) and buffers it in a small byte FIFO.
- Decodes UTF-8 into 21-bit code points and presents each one as a single-cycle `unicode`/`unicode_available` pulse.
- Paces output with the consumer's active-low `ready_n`. Malformed input is replaced by U+FFFD so the terminal never stalls on bad data.

---
 rtl/utf8_stream_decoder_pkg.sv | 39 +++
 rtl/utf8_stream_decoder_byte_fifo.sv | 55 +++++
 rtl/utf8_stream_decoder.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/utf8_stream_decoder_pkg.sv
// Shared constants, state encodings and validity helpers for the UTF-8 stream decoder.
package utf8_stream_decoder_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CP_W   = 21;

  localparam logic [CP_W-1:0] REPLACEMENT_CHARACTER = 21'h00FFFD;

  // Lead/continuation classification: (byte & MASK) == BITS
  localparam logic [BYTE_W-1:0] CONT_MASK  = 8'hC0;
  localparam logic [BYTE_W-1:0] CONT_BITS  = 8'h80;
  localparam logic [BYTE_W-1:0] LEAD2_MASK = 8'hE0;
  localparam logic [BYTE_W-1:0] LEAD2_BITS = 8'hC0;
  localparam logic [BYTE_W-1:0] LEAD3_MASK = 8'hF0;
  localparam logic [BYTE_W-1:0] LEAD3_BITS = 8'hE0;
  localparam logic [BYTE_W-1:0] LEAD4_MASK = 8'hF8;
  localparam logic [BYTE_W-1:0] LEAD4_BITS = 8'hF0;

  typedef enum logic [1:0] {
    S_LEAD = 2'd0,
    S_CONT = 2'd1,
    S_EMIT = 2'd2
  } dec_state_e;

  // Leads that can only start an overlong or out-of-range sequence.
  function automatic logic lead_reject(input logic [BYTE_W-1:0] b);
    return (b[7:1] == 7'b1100000) || (b >= 8'hF5 && b <= 8'hF7);
  endfunction

  // Overlong, surrogate or beyond-U+10FFFF results; cont_len is the continuation count.
  function automatic logic cp_invalid(input logic [CP_W-1:0] cp, input logic [1:0] cont_len);
    logic overlong;
    overlong = ((cont_len == 2'd1) && (cp < 21'h000080)) ||
               ((cont_len == 2'd2) && (cp < 21'h000800)) ||
               ((cont_len == 2'd3) && (cp < 21'h010000));
    return overlong || (cp >= 21'h00D800 && cp <= 21'h00DFFF) || (cp > 21'h10FFFF);
  endfunction

endpackage

// File: rtl/utf8_stream_decoder_byte_fifo.sv
// Synchronous byte FIFO with registered full/empty/count; a write while full is dropped.
module utf8_stream_decoder_byte_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data_c,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok_c;
  logic             rd_ok_c;
  logic [CW-1:0]    count_d_c;

  assign wr_ok_c   = wr_en && !full;
  assign rd_ok_c   = rd_en && !empty;
  assign rd_data_c = mem[rd_ptr];

  always_comb begin
    count_d_c = count + CW'(wr_ok_c) - CW'(rd_ok_c);
  end

  always_ff @(posedge clk) begin
    if (wr_ok_c) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_ok_c) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok_c) rd_ptr <= rd_ptr + AW'(1);
      count <= count_d_c;
      full  <= (count_d_c == CW'(DEPTH));
      empty <= (count_d_c == CW'(0));
    end
  end

endmodule

// File: rtl/utf8_stream_decoder.sv
// Byte stream -> UTF-8 code point pulses paced by sink_ready_n; malformed input becomes REPLACEMENT.
// Define UTF8_STRICT_EN to also reject overlong, surrogate and out-of-range results.
module utf8_stream_decoder
  import utf8_stream_decoder_pkg::*;
#(
  parameter int unsigned      FIFO_DEPTH  = 16,
  parameter logic [CP_W-1:0]  REPLACEMENT = REPLACEMENT_CHARACTER
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_available,
  output logic              fifo_full,
  output logic              overflow,
  input  logic              sink_ready_n,
  output logic [CP_W-1:0]   unicode,
  output logic              unicode_available
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [BYTE_W-1:0] fifo_rd_c;
  logic              fifo_empty;
  logic              pop_c;
  logic [CNT_W-1:0]  unused_fifo_count;

  utf8_stream_decoder_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (byte_available),
    .wr_data   (byte_in),
    .rd_en     (pop_c),
    .rd_data_c (fifo_rd_c),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (unused_fifo_count)
  );

  dec_state_e      state_q, state_d;
  logic [1:0]      need_q, need_d;
  logic [CP_W-1:0] acc_q, acc_d;
  logic            armed_q, armed_d;
  logic [1:0]      gap_q, gap_d;
  logic [CP_W-1:0] unicode_d;
  logic            avail_d;
`ifdef UTF8_STRICT_EN
  logic [1:0]      len_q, len_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= S_LEAD;
      need_q            <= '0;
      acc_q             <= '0;
      armed_q           <= 1'b0;
      gap_q             <= '0;
      unicode           <= '0;
      unicode_available <= 1'b0;
      overflow          <= 1'b0;
`ifdef UTF8_STRICT_EN
      len_q             <= '0;
`endif
    end else begin
      state_q           <= state_d;
      need_q            <= need_d;
      acc_q             <= acc_d;
      armed_q           <= armed_d;
      gap_q             <= gap_d;
      unicode           <= unicode_d;
      unicode_available <= avail_d;
      if (byte_available && fifo_full) overflow <= 1'b1;
`ifdef UTF8_STRICT_EN
      len_q             <= len_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    need_d    = need_q;
    acc_d     = acc_q;
    armed_d   = armed_q;
    gap_d     = gap_q;
    unicode_d = unicode;
    avail_d   = 1'b0;
    pop_c     = 1'b0;
`ifdef UTF8_STRICT_EN
    len_d     = len_q;
`endif
    case (state_q)
      S_LEAD: begin
        if (!fifo_empty) begin
          pop_c = 1'b1;
          if (fifo_rd_c[7] == 1'b0) begin
            acc_d   = CP_W'(fifo_rd_c);
            state_d = S_EMIT;
          end else if ((fifo_rd_c & LEAD2_MASK) == LEAD2_BITS) begin
            acc_d   = CP_W'(fifo_rd_c[4:0]);
            need_d  = 2'd1;
            state_d = S_CONT;
          end else if ((fifo_rd_c & LEAD3_MASK) == LEAD3_BITS) begin
            acc_d   = CP_W'(fifo_rd_c[3:0]);
            need_d  = 2'd2;
            state_d = S_CONT;
          end else if ((fifo_rd_c & LEAD4_MASK) == LEAD4_BITS) begin
            acc_d   = CP_W'(fifo_rd_c[2:0]);
            need_d  = 2'd3;
            state_d = S_CONT;
          end else begin
            acc_d   = REPLACEMENT;
            state_d = S_EMIT;
          end
`ifdef UTF8_STRICT_EN
          len_d = need_d;
          if (lead_reject(fifo_rd_c)) begin
            acc_d   = REPLACEMENT;
            state_d = S_EMIT;
          end
`endif
        end
      end
      S_CONT: begin
        // A non-continuation byte stays in the FIFO and is decoded next as a lead.
        if (!fifo_empty) begin
          if ((fifo_rd_c & CONT_MASK) == CONT_BITS) begin
            pop_c  = 1'b1;
            acc_d  = {acc_q[14:0], fifo_rd_c[5:0]};
            need_d = need_q - 2'd1;
            if (need_q == 2'd1) begin
              state_d = S_EMIT;
`ifdef UTF8_STRICT_EN
              if (cp_invalid(acc_d, len_q)) acc_d = REPLACEMENT;
`endif
            end
          end else begin
            acc_d   = REPLACEMENT;
            state_d = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        // Arm on a sampled ready, pulse on the next edge, then hold off three cycles.
        if (gap_q != 2'd0) begin
          gap_d = gap_q - 2'd1;
          if (gap_q == 2'd1) state_d = S_LEAD;
        end else if (armed_q) begin
          avail_d   = 1'b1;
          unicode_d = acc_q;
          armed_d   = 1'b0;
          gap_d     = 2'd3;
        end else if (!sink_ready_n) begin
          armed_d = 1'b1;
        end
      end
      default: state_d = S_LEAD;
    endcase
  end

endmodule
